// File: rtl/mem_access_seq_if.sv
// Command and memory-port bundle for the memory access sequencer.
// The master modport is the sequencer; the slave modport is the control unit and memory side.
interface mem_access_seq_if #(
    parameter int WORD_WIDTH = 31
);
    logic [11:0]           reg_select_value;
    logic                  do_mem_read;
    logic                  do_mem_write;
    logic [WORD_WIDTH-1:0] write_data;
    logic                  mem_req;
    logic                  mem_we;
    logic [11:0]           mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic [WORD_WIDTH-1:0] read_data;
    logic                  busy;
    logic                  access_done;
    logic                  addr_error;
    logic                  timeout_error;

    modport master (
        input  reg_select_value, do_mem_read, do_mem_write, write_data, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, read_data, busy, access_done,
               addr_error, timeout_error
    );

    modport slave (
        output reg_select_value, do_mem_read, do_mem_write, write_data, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, read_data, busy, access_done,
               addr_error, timeout_error
    );
endinterface

// File: rtl/mem_access_seq.sv
// Memory access sequencer: one read or write per command over a req/ack port,
// with a read data register, out-of-range address check and ack timeout.
module mem_access_seq #(
    parameter int WORD_WIDTH  = 31,
    parameter int MEM_DEPTH   = 2048,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetn,
    mem_access_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} state_e;

    state_e                state_q, state_d;
    logic [11:0]           addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  req_q, req_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  addr_err_q, addr_err_d;
    logic                  to_err_q, to_err_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            to_err_q   <= to_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        to_err_d   = to_err_q;
        case (state_q)
            IDLE: begin
                // Read wins when both commands arrive together.
                if (bus.do_mem_read || bus.do_mem_write) begin
                    addr_d     = bus.reg_select_value;
                    we_d       = !bus.do_mem_read;
                    if (!bus.do_mem_read)
                        wdata_d = bus.write_data;
                    addr_err_d = 1'b0;
                    to_err_d   = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (32'(addr_q) >= 32'(MEM_DEPTH)) begin
                    addr_err_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    req_d   = 1'b1;
                    cnt_d   = 8'(ACK_TIMEOUT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                // An ack in the last allowed cycle still counts as success.
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    if (!we_q)
                        rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == 8'd1) begin
                    req_d    = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req       = req_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.read_data     = rdata_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.access_done   = (state_q == DONE);
    assign bus.addr_error    = addr_err_q;
    assign bus.timeout_error = to_err_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: table of single accesses plus hand-written
// sequences for overlapping commands and reset during an access.
module tb_mem_access_seq;
    localparam int W = 31;

    logic clk;
    logic resetn;

    mem_access_seq_if #(.WORD_WIDTH(W)) bus ();

    mem_access_seq #(.WORD_WIDTH(W), .MEM_DEPTH(2048), .ACK_TIMEOUT(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // op: 0 read, 1 write, 2 read+write together. n = ack delay after mem_req rises, 255 = never.
    typedef struct {
        int          op;
        logic [11:0] addr;
        logic [W-1:0] wdata;
        int          n;
        logic [W-1:0] rdata;
        int          exp_lat;
        int          exp_reqs;
        logic        exp_we;
        logic [W-1:0] exp_rd;
        logic        exp_ae;
        logic        exp_te;
    } vec_t;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [11:0] addr, input logic [W-1:0] wdata,
                                input int n, input logic [W-1:0] rdata, input int lat, input int reqs,
                                input logic we, input logic [W-1:0] rd, input logic ae, input logic te);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.n = n; v.rdata = rdata;
        v.exp_lat = lat; v.exp_reqs = reqs; v.exp_we = we; v.exp_rd = rd;
        v.exp_ae = ae; v.exp_te = te;
        return v;
    endfunction

    task automatic drive_cmd(input int op, input logic [11:0] addr, input logic [W-1:0] wdata);
        bus.reg_select_value = addr;
        bus.write_data       = wdata;
        bus.do_mem_read      = (op == 0 || op == 2);
        bus.do_mem_write     = (op == 1 || op == 2);
    endtask

    task automatic run(input vec_t v, input int idx);
        int rise, reqs, lat;
        logic we_bad, addr_bad, wd_bad;
        string tag;
        tag = $sformatf("v%0d", idx);
        rise = -1; reqs = 0; lat = -1;
        we_bad = 1'b0; addr_bad = 1'b0; wd_bad = 1'b0;
        @(negedge clk);
        drive_cmd(v.op, v.addr, v.wdata);
        bus.mem_rdata = v.rdata;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            bus.do_mem_read  = 1'b0;
            bus.do_mem_write = 1'b0;
            if (bus.mem_req) begin
                if (rise < 0) rise = c;
                reqs++;
                if (bus.mem_we !== v.exp_we) we_bad = 1'b1;
                if (bus.mem_addr !== v.addr) addr_bad = 1'b1;
                if (v.exp_we && bus.mem_wdata !== v.wdata) wd_bad = 1'b1;
            end
            bus.mem_ack = bus.mem_req && (rise >= 0) && (c == rise + v.n);
            if (bus.access_done) begin
                lat = c;
                check({tag, " read_data"}, 64'(bus.read_data), 64'(v.exp_rd));
                check({tag, " addr_error"}, 64'(bus.addr_error), 64'(v.exp_ae));
                check({tag, " timeout_error"}, 64'(bus.timeout_error), 64'(v.exp_te));
                check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(v.addr));
            end
        end
        bus.mem_ack = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " req cycles"}, 64'(reqs), 64'(v.exp_reqs));
        check({tag, " mem_we bad"}, 64'(we_bad), 64'd0);
        check({tag, " mem_addr bad"}, 64'(addr_bad), 64'd0);
        check({tag, " mem_wdata bad"}, 64'(wd_bad), 64'd0);
        @(negedge clk);
        check({tag, " busy after done"}, 64'(bus.busy), 64'd0);
        check({tag, " access_done after"}, 64'(bus.access_done), 64'd0);
    endtask

    vec_t vt[9];

    initial begin
        int dones, rise;
        logic addr_bad, we_bad;

        vt[0] = mk(0, 12'h005, 31'h0,        2,   31'h12345678, 5,  3,  1'b0, 31'h12345678, 1'b0, 1'b0);
        vt[1] = mk(1, 12'h7FF, 31'h2AAAAAAA, 1,   31'h0BADBEEF, 4,  2,  1'b1, 31'h12345678, 1'b0, 1'b0);
        vt[2] = mk(0, 12'h800, 31'h0,        1,   31'h0BADBEEF, 2,  0,  1'b0, 31'h12345678, 1'b1, 1'b0);
        vt[3] = mk(0, 12'h010, 31'h0,        3,   31'h00C0FFEE, 6,  4,  1'b0, 31'h00C0FFEE, 1'b0, 1'b0);
        vt[4] = mk(0, 12'h020, 31'h0,        255, 31'h0BADBEEF, 17, 15, 1'b0, 31'h00C0FFEE, 1'b0, 1'b1);
        vt[5] = mk(0, 12'h021, 31'h0,        14,  31'h7FFFFFFF, 17, 15, 1'b0, 31'h7FFFFFFF, 1'b0, 1'b0);
        vt[6] = mk(2, 12'h0FF, 31'h00001111, 1,   31'h5A5A5A5A, 4,  2,  1'b0, 31'h5A5A5A5A, 1'b0, 1'b0);
        vt[7] = mk(0, 12'hFFF, 31'h0,        1,   31'h0BADBEEF, 2,  0,  1'b0, 31'h5A5A5A5A, 1'b1, 1'b0);
        vt[8] = mk(1, 12'h000, 31'h13572468, 5,   31'h0BADBEEF, 8,  6,  1'b1, 31'h5A5A5A5A, 1'b0, 1'b0);

        resetn = 1'b0;
        drive_cmd(3, 12'h0, '0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset mem_req", 64'(bus.mem_req), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset read_data", 64'(bus.read_data), 64'd0);
        check("reset mem_addr", 64'(bus.mem_addr), 64'd0);
        check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("reset errors", 64'({bus.addr_error, bus.timeout_error, bus.access_done}), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) run(vt[i], i);

        // Write pulsed while a read is in flight must be dropped.
        @(negedge clk);
        drive_cmd(0, 12'h030, '0);
        bus.mem_rdata = 31'h00000003;
        dones = 0; rise = -1; addr_bad = 1'b0; we_bad = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) drive_cmd(1, 12'h040, 31'h7777);
            else drive_cmd(3, 12'h040, 31'h7777);
            if (bus.mem_req && rise < 0) rise = c;
            if (bus.busy && bus.mem_addr !== 12'h030) addr_bad = 1'b1;
            if (bus.mem_req && bus.mem_we !== 1'b0) we_bad = 1'b1;
            bus.mem_ack = bus.mem_req && (rise >= 0) && (c == rise + 3);
            if (bus.access_done) dones++;
        end
        bus.mem_ack = 1'b0;
        check("overlap done count", 64'(dones), 64'd1);
        check("overlap mem_addr held", 64'(addr_bad), 64'd0);
        check("overlap mem_we", 64'(we_bad), 64'd0);
        check("overlap read_data", 64'(bus.read_data), 64'h3);

        // Reset while waiting for ack; the late ack must not complete anything.
        @(negedge clk);
        drive_cmd(0, 12'h050, '0);
        bus.mem_rdata = 31'h0BADBEEF;
        @(negedge clk);
        drive_cmd(3, 12'h0, '0);
        repeat (3) @(negedge clk);
        check("pre-reset mem_req", 64'(bus.mem_req), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("mid reset mem_req", 64'(bus.mem_req), 64'd0);
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset read_data", 64'(bus.read_data), 64'd0);
        resetn = 1'b1;
        bus.mem_ack = 1'b1;
        dones = 0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.access_done || bus.busy) dones++;
            @(negedge clk);
        end
        check("late ack ignored", 64'(dones), 64'd0);
        check("late ack read_data", 64'(bus.read_data), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Memory access sequencer directly downstream of the select register; consumes the 12-bit selected address (reg_select_value) and performs one read or one write of main memory per command.
- Commands come from the control unit.
- Drives a req/ack memory port, latches read data into a memory data register, flags out-of-range addresses and ack timeouts.

Parameters:
- WORD_WIDTH, 31, memory word width in bits.
- MEM_DEPTH, 2048, number of implemented words; addresses >= MEM_DEPTH are out of range.
- ACK_TIMEOUT, 15, cycles allowed in WAIT before abort; legal range 1..255.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- reg_select_value  in  12  selected address from the select register.
- do_mem_read  in  1  start read command; single-cycle pulse, sampled only in IDLE.
- do_mem_write  in  1  start write command; single-cycle pulse, sampled only in IDLE.
- write_data  in  WORD_WIDTH  data to write; sampled with do_mem_write.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  12  latched address.
- mem_wdata  out  WORD_WIDTH  latched write data.
- mem_ack  in  1  memory acknowledge; one-cycle pulse.
- mem_rdata  in  WORD_WIDTH  read data; valid in the mem_ack cycle.
- read_data  out  WORD_WIDTH  memory data register.
- busy  out  1  high whenever state is not IDLE.
- access_done  out  1  one-cycle completion pulse.
- addr_error  out  1  sticky out-of-range flag.
- timeout_error  out  1  sticky ack-timeout flag.

Behaviour:
- Reset: resetn = 0 at a clock edge puts the block in IDLE and clears all outputs to 0, including read_data, mem_addr, mem_wdata, both error flags and the timeout counter. This applies in any state. An in-flight request is dropped, and an ack in the following cycle is ignored.
- States: IDLE, CHECK, WAIT, DONE.
- IDLE:
  - do_mem_read or do_mem_write high: latch reg_select_value into mem_addr, latch write_data into mem_wdata (writes only), set mem_we to the command type, go to CHECK.
  - Both high in the same cycle: read takes priority; write is ignored and no flag is set.
  - Commands arriving outside IDLE are ignored with no queueing; the control unit must wait for busy to fall.
- CHECK:
  - mem_addr >= MEM_DEPTH: set addr_error, no memory request, go to DONE.
  - Otherwise: assert mem_req, load the timeout counter with ACK_TIMEOUT, go to WAIT.
- WAIT:
  - mem_req stays high; the counter decrements each cycle.
  - mem_ack = 1: drop mem_req on the next edge. On a read, load mem_rdata into read_data on that same edge. Go to DONE.
  - Counter reaches 0 with no ack: set timeout_error, drop mem_req, go to DONE; read_data is unchanged.
  - Ack in the same cycle the counter reaches 0: the ack wins and no timeout is recorded.
- DONE: access_done = 1 for exactly this one cycle, then return to IDLE.
- Latency from command to access_done:
  - Normal access: 3 + N cycles, where N = cycles from mem_req rising to mem_ack (N >= 1).
  - Address error: 2 cycles.
- read_data holds its value until the next successful read; writes never alter it.
- mem_addr and mem_wdata are held stable from CHECK through DONE.
- mem_ack outside WAIT is ignored.
- Error flags:
  - Each stays set until the next accepted command; on acceptance both flags clear.
  - Both are valid in the access_done cycle.
- mem_addr is always the full 12 bits; there is no wrap-around or truncation.

Test Plan:
- Read, in range: reg_select_value = 0x005, do_mem_read pulse, memory acks 2 cycles after mem_req with 0x1234_5678 -> mem_we = 0, mem_addr = 0x005, read_data = 0x12345678, access_done 5 cycles after the command, busy low the cycle after.
- Write: reg_select_value = 0x7FF, write_data = 0x2AAA_AAAA, do_mem_write, ack after 1 cycle -> mem_we = 1, mem_wdata = 0x2AAAAAAA while mem_req is high, read_data unchanged, no errors.
- Out of range: reg_select_value = 0x800, do_mem_read -> mem_req never rises, addr_error = 1 at access_done (2 cycles after the command); the next valid command clears addr_error.
- Timeout: read with mem_ack held low -> mem_req high for exactly 15 cycles, timeout_error = 1, read_data unchanged. Then repeat with the ack placed in the final (15th) WAIT cycle -> success, timeout_error = 0.
- Simultaneous and overlapping commands: do_mem_read and do_mem_write in the same cycle -> read performed. do_mem_write pulsed while busy -> ignored, no second access_done.
- Reset mid-access: resetn low while in WAIT -> mem_req = 0, busy = 0, read_data = 0 the next cycle; an ack arriving the cycle after reset causes no access_done.
